// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: default register
// index width and the EX operand forwarding select encodings.
package pipe_pkg;
  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave):
// ID-stage decode info in, stall/flush/forward/valid controls out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_wreg;
  logic                  id_regwrite;
  logic                  id_memtoreg;
  logic                  id_mdu;
  logic                  ex_branch_taken;
  logic                  stall_if;
  logic                  stall_id;
  logic                  flush_id;
  logic                  flush_ex;
  logic [1:0]            forward_a;
  logic [1:0]            forward_b;
  logic                  mdu_busy;
  logic                  valid_ex;
  logic                  valid_mem;
  logic                  valid_wb;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_wreg,
           id_regwrite, id_memtoreg, id_mdu, ex_branch_taken,
    input  stall_if, stall_id, flush_id, flush_ex, forward_a, forward_b,
           mdu_busy, valid_ex, valid_mem, valid_wb
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_wreg,
           id_regwrite, id_memtoreg, id_mdu, ex_branch_taken,
    output stall_if, stall_id, flush_id, flush_ex, forward_a, forward_b,
           mdu_busy, valid_ex, valid_mem, valid_wb
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX source operand; the MEM-stage writer wins
// over the WB-stage writer because it holds the younger value.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_wreg,
  input  logic                  wb_valid,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_wreg,
  output logic [1:0]            sel
);
  // r0 is hardwired zero, so a write to it never produces a forward
  function automatic logic hit(logic v, logic rw, logic [REG_ADDR_W-1:0] wreg,
                               logic [REG_ADDR_W-1:0] s);
    return v && rw && (wreg != '0) && (wreg == s);
  endfunction

  always_comb begin
    sel = FWD_REG;
    if (hit(mem_valid, mem_regwrite, mem_wreg, src)) sel = FWD_MEM;
    else if (hit(wb_valid, wb_regwrite, wb_wreg, src)) sel = FWD_WB;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interlock controller for the 5-stage pipeline: shadows EX/MEM/WB,
// forwards operands, stalls on load-use and multi-cycle MDU ops, flushes on taken branches.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int MDU_LATENCY = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int CNT_W = $clog2(MDU_LATENCY) + 1;
  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_LATENCY - 1);

  logic                  valid_ex, ex_regwrite, ex_memtoreg, ex_mdu;
  logic [REG_ADDR_W-1:0] ex_wreg, ex_rs, ex_rt;
  logic                  valid_mem, mem_regwrite;
  logic [REG_ADDR_W-1:0] mem_wreg;
  logic                  valid_wb, wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_wreg;
  logic [CNT_W-1:0]      cnt;

  logic busy, taken, load_use, flush_ex;

  always_comb begin
    busy     = valid_ex && ex_mdu && (cnt != '0);
    taken    = valid_ex && hz.ex_branch_taken && !busy;
    load_use = valid_ex && ex_memtoreg && ex_regwrite && (ex_wreg != '0) &&
               ((hz.id_uses_rs && (ex_wreg == hz.id_rs)) ||
                (hz.id_uses_rt && (ex_wreg == hz.id_rt)));
    // a taken branch squashes the dependent instruction, so no stall is needed
    flush_ex = taken || (load_use && !busy);
  end

  assign hz.mdu_busy  = busy;
  assign hz.stall_if  = busy || (load_use && !taken);
  assign hz.stall_id  = busy || (load_use && !taken);
  assign hz.flush_id  = taken;
  assign hz.flush_ex  = flush_ex;
  assign hz.valid_ex  = valid_ex;
  assign hz.valid_mem = valid_mem;
  assign hz.valid_wb  = valid_wb;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src(ex_rs), .mem_valid(valid_mem), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_valid(valid_wb), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .sel(hz.forward_a)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src(ex_rt), .mem_valid(valid_mem), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_valid(valid_wb), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .sel(hz.forward_b)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_ex     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memtoreg  <= 1'b0;
      ex_mdu       <= 1'b0;
      ex_wreg      <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      cnt          <= '0;
      valid_mem    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_wreg     <= '0;
      valid_wb     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_wreg      <= '0;
    end else begin
      // ID -> EX: MDU op holds EX, a flush leaves a bubble, otherwise load
      if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end else if (flush_ex) begin
        valid_ex <= 1'b0;
        cnt      <= '0;
      end else begin
        valid_ex    <= 1'b1;
        ex_rs       <= hz.id_rs;
        ex_rt       <= hz.id_rt;
        ex_wreg     <= hz.id_wreg;
        ex_regwrite <= hz.id_regwrite;
        ex_memtoreg <= hz.id_memtoreg;
        ex_mdu      <= hz.id_mdu;
        cnt         <= hz.id_mdu ? MDU_LOAD : '0;
      end
      // EX -> MEM: bubble while the MDU op is still occupying EX
      valid_mem    <= valid_ex && !busy;
      mem_wreg     <= ex_wreg;
      mem_regwrite <= ex_regwrite;
      // MEM -> WB
      valid_wb     <= valid_mem;
      wb_wreg      <= mem_wreg;
      wb_regwrite  <= mem_regwrite;
    end
  end
endmodule
